// File: rtl/oam_dma_controller_if.sv
// Signal bundle between the sprite DMA sequencer and its CPU bus, system-bus and PPU OAM neighbours.
// The master modport is the DMA controller's view; slave is the surrounding system's view.
interface oam_dma_controller_if;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_data;
    logic        cpu_rw_n;
    logic        dma_active;
    logic        bus_own;
    logic [15:0] bus_addr;
    logic        bus_rden;
    logic [7:0]  bus_data;
    logic        oam_wren;
    logic [7:0]  oam_addr;
    logic [7:0]  oam_data;
    logic        done;

    modport master (
        input  cpu_addr, cpu_data, cpu_rw_n, bus_data,
        output dma_active, bus_own, bus_addr, bus_rden,
        output oam_wren, oam_addr, oam_data, done
    );

    modport slave (
        output cpu_addr, cpu_data, cpu_rw_n, bus_data,
        input  dma_active, bus_own, bus_addr, bus_rden,
        input  oam_wren, oam_addr, oam_data, done
    );
endinterface

// File: rtl/oam_dma_controller.sv
// $4014 sprite DMA sequencer: HALT, optional ALIGN, then XFER_LEN READ/WRITE pairs into OAM.
// Define OAM_DMA_ODD_ALIGN_EN to track CPU get/put parity and insert the ALIGN cycle.
module oam_dma_controller #(
    parameter logic [15:0] REG_ADDR = 16'h4014,
    parameter int          XFER_LEN = 256
) (
    input logic CLK,
    input logic RESET_n,
    oam_dma_controller_if.master bus
);
    typedef enum logic [2:0] {IDLE, HALT, ALIGN, READ, WRITE} state_t;

    localparam logic [7:0] LAST_IDX = 8'(XFER_LEN - 1);

    state_t      state_q, state_d;
    logic [7:0]  page_q, page_d;
    logic [7:0]  idx_q, idx_d;
    logic        dma_active_q, dma_active_d;
    logic        bus_own_q, bus_own_d;
    logic [15:0] bus_addr_q, bus_addr_d;
    logic        bus_rden_q, bus_rden_d;
    logic        oam_wren_q, oam_wren_d;
    logic [7:0]  oam_addr_q, oam_addr_d;
    logic [7:0]  oam_data_q, oam_data_d;
    logic        done_q, done_d;
    logic        trigger;
`ifdef OAM_DMA_ODD_ALIGN_EN
    logic        parity_q, parity_d;
`endif

    assign trigger = !bus.cpu_rw_n && (bus.cpu_addr == REG_ADDR);

    always_comb begin
        state_d    = state_q;
        page_d     = page_q;
        idx_d      = idx_q;
        oam_data_d = oam_data_q;
`ifdef OAM_DMA_ODD_ALIGN_EN
        parity_d   = !parity_q;
`endif
        case (state_q)
            IDLE: begin
                if (trigger) begin
                    page_d  = bus.cpu_data;
                    idx_d   = 8'd0;
                    state_d = HALT;
                end
            end
            HALT: begin
`ifdef OAM_DMA_ODD_ALIGN_EN
                // parity 1 now means the next cycle is a get cycle, so READ can follow directly
                state_d = parity_q ? READ : ALIGN;
`else
                state_d = READ;
`endif
            end
            ALIGN: state_d = READ;
            READ:  state_d = WRITE;
            WRITE: begin
                oam_data_d = bus.bus_data;
                if (idx_q == LAST_IDX) begin
                    state_d = IDLE;
                end else begin
                    idx_d   = idx_q + 8'd1;
                    state_d = READ;
                end
            end
            default: state_d = IDLE;
        endcase

        // Outputs are registered from the next state so they line up with the state they describe
        dma_active_d = (state_d != IDLE);
        bus_own_d    = (state_d == READ) || (state_d == WRITE);
        bus_rden_d   = (state_d == READ);
        oam_wren_d   = (state_d == WRITE);
        done_d       = (state_d == WRITE) && (idx_d == LAST_IDX);
        bus_addr_d   = bus_own_d ? {page_d, idx_d} : bus_addr_q;
        oam_addr_d   = oam_wren_d ? idx_d : oam_addr_q;
    end

    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            state_q      <= IDLE;
            page_q       <= 8'd0;
            idx_q        <= 8'd0;
            dma_active_q <= 1'b0;
            bus_own_q    <= 1'b0;
            bus_addr_q   <= 16'd0;
            bus_rden_q   <= 1'b0;
            oam_wren_q   <= 1'b0;
            oam_addr_q   <= 8'd0;
            oam_data_q   <= 8'd0;
            done_q       <= 1'b0;
`ifdef OAM_DMA_ODD_ALIGN_EN
            parity_q     <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            page_q       <= page_d;
            idx_q        <= idx_d;
            dma_active_q <= dma_active_d;
            bus_own_q    <= bus_own_d;
            bus_addr_q   <= bus_addr_d;
            bus_rden_q   <= bus_rden_d;
            oam_wren_q   <= oam_wren_d;
            oam_addr_q   <= oam_addr_d;
            oam_data_q   <= oam_data_d;
            done_q       <= done_d;
`ifdef OAM_DMA_ODD_ALIGN_EN
            parity_q     <= parity_d;
`endif
        end
    end

    assign bus.dma_active = dma_active_q;
    assign bus.bus_own    = bus_own_q;
    assign bus.bus_addr   = bus_addr_q;
    assign bus.bus_rden   = bus_rden_q;
    assign bus.oam_wren   = oam_wren_q;
    assign bus.oam_addr   = oam_addr_q;
    assign bus.done       = done_q;
    // Read data only arrives during WRITE, so it passes straight through and is kept for idle hold
    assign bus.oam_data   = (state_q == WRITE) ? bus.bus_data : oam_data_q;
endmodule

// File: tb/tb_oam_dma_controller.sv
// Bench for oam_dma_controller: transfer-offset model checked every cycle, plus literal lengths/addresses.
module tb_oam_dma_controller;
    localparam logic [15:0] REG_ADDR = 16'h4014;
    localparam int          XFER_LEN = 256;
`ifdef OAM_DMA_ODD_ALIGN_EN
    localparam bit ALIGN_EN = 1'b1;
`else
    localparam bit ALIGN_EN = 1'b0;
`endif

    logic CLK = 1'b0;
    logic RESET_n;
    int   total = 0;
    int   bad = 0;

    oam_dma_controller_if dif ();

    oam_dma_controller #(.REG_ADDR(REG_ADDR), .XFER_LEN(XFER_LEN)) dut (
        .CLK    (CLK),
        .RESET_n(RESET_n),
        .bus    (dif.master)
    );

    always #5 CLK = ~CLK;

    function automatic logic [7:0] ramval(input logic [15:0] a);
        return a[7:0] ^ 8'(a[15:8] * 8'd29) ^ 8'h5A;
    endfunction

    // System memory: data appears the cycle after the read strobe
    always @(posedge CLK) begin
        if (dif.bus_rden) dif.bus_data <= ramval(dif.bus_addr);
    end

    // Model state: position within the transfer, counted in cycles from the trigger edge
    bit          m_busy = 0;
    bit          m_align = 0;
    int          m_off = 0;
    int          ncyc = 0;
    logic [7:0]  m_page = 0;
    logic [15:0] l_baddr = 0;
    logic [7:0]  l_oaddr = 0, l_odata = 0;
    logic        e_act = 0, e_own = 0, e_rden = 0, e_wren = 0, e_done = 0;

    initial forever begin
        int k;
        int idx;
        @(posedge CLK or negedge RESET_n);
        if (!RESET_n) begin
            m_busy = 0; m_off = 0; m_align = 0; m_page = 0; ncyc = 0;
            l_baddr = 0; l_oaddr = 0; l_odata = 0;
        end else begin
            ncyc++;
            if (m_busy) begin
                m_off++;
                if (m_off == 1 + int'(m_align) + 2 * XFER_LEN) m_busy = 0;
            end else if (dif.cpu_rw_n == 1'b0 && dif.cpu_addr == REG_ADDR) begin
                m_busy  = 1;
                m_off   = 0;
                m_page  = dif.cpu_data;
                m_align = ALIGN_EN && (ncyc % 2 == 0);
            end
        end
        e_act = m_busy; e_own = 0; e_rden = 0; e_wren = 0; e_done = 0;
        if (m_busy && m_off > int'(m_align)) begin
            k       = m_off - 1 - int'(m_align);
            idx     = k / 2;
            e_own   = 1;
            l_baddr = {m_page, 8'(idx)};
            if (k % 2 == 0) begin
                e_rden = 1;
            end else begin
                e_wren  = 1;
                l_oaddr = 8'(idx);
                l_odata = ramval(l_baddr);
                e_done  = (idx == XFER_LEN - 1);
            end
        end
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            if (bad <= 30) $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Monitor counters, cleared by the stimulus between scenarios
    int          act_len = 0, wr_cnt = 0, rd_cnt = 0, done_cnt = 0, first_rd_at = 0;
    logic [15:0] first_rd = 0, last_rd = 0;

    always @(negedge CLK) begin
        chk("dma_active", 16'(dif.dma_active), 16'(e_act));
        chk("bus_own", 16'(dif.bus_own), 16'(e_own));
        chk("bus_rden", 16'(dif.bus_rden), 16'(e_rden));
        chk("bus_addr", dif.bus_addr, l_baddr);
        chk("oam_wren", 16'(dif.oam_wren), 16'(e_wren));
        chk("oam_addr", 16'(dif.oam_addr), 16'(l_oaddr));
        chk("oam_data", 16'(dif.oam_data), 16'(l_odata));
        chk("done", 16'(dif.done), 16'(e_done));
        if (dif.dma_active) act_len++;
        if (dif.oam_wren) wr_cnt++;
        if (dif.done) done_cnt++;
        if (dif.bus_rden) begin
            if (rd_cnt == 0) begin
                first_rd    = dif.bus_addr;
                first_rd_at = act_len;
            end
            last_rd = dif.bus_addr;
            rd_cnt++;
        end
    end

    task automatic step();
        @(negedge CLK);
        #1;
    endtask

    task automatic clr();
        act_len = 0; wr_cnt = 0; rd_cnt = 0; done_cnt = 0; first_rd_at = 0;
        first_rd = 0; last_rd = 0;
    endtask

    task automatic cpu_access(input logic [15:0] a, input logic [7:0] d, input logic rw_n);
        dif.cpu_addr = a; dif.cpu_data = d; dif.cpu_rw_n = rw_n;
        step();
        dif.cpu_addr = 16'h0000; dif.cpu_data = 8'h00; dif.cpu_rw_n = 1'b1;
    endtask

    // Position so the HALT cycle after the next edge sees the requested parity
    task automatic align_to(input int p);
        while ((ncyc + 1) % 2 != p) step();
    endtask

    task automatic wait_xfer(input int budget);
        int n = 0;
        while (!(act_len > 0 && !dif.dma_active) && n < budget) begin
            step();
            n++;
        end
        total++;
        if (n >= budget) begin
            bad++;
            $display("FAIL wait_xfer: transfer not finished after %0d cycles (act_len=%0d)", n, act_len);
        end
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_dma_active"}, 16'(dif.dma_active), 16'd0);
        chk({tag, "_bus_own"}, 16'(dif.bus_own), 16'd0);
        chk({tag, "_bus_rden"}, 16'(dif.bus_rden), 16'd0);
        chk({tag, "_bus_addr"}, dif.bus_addr, 16'd0);
        chk({tag, "_oam_wren"}, 16'(dif.oam_wren), 16'd0);
        chk({tag, "_oam_addr"}, 16'(dif.oam_addr), 16'd0);
        chk({tag, "_oam_data"}, 16'(dif.oam_data), 16'd0);
        chk({tag, "_done"}, 16'(dif.done), 16'd0);
    endtask

    initial begin
        int n;
        RESET_n = 1'b1;
        dif.cpu_addr = 16'h0000; dif.cpu_data = 8'h00; dif.cpu_rw_n = 1'b1;
        dif.bus_data = 8'h00;
        #2 RESET_n = 1'b0;
        repeat (3) step();
        chk_zero_outputs("reset");
        RESET_n = 1'b1;
        step();

        // Trigger landing with parity 1 in HALT: no ALIGN in either build
        align_to(1); clr();
        cpu_access(REG_ADDR, 8'h02, 1'b0);
        wait_xfer(700);
        chk("p1_len", 16'(act_len), 16'd513);
        chk("p1_writes", 16'(wr_cnt), 16'd256);
        chk("p1_done_cnt", 16'(done_cnt), 16'd1);
        chk("p1_first_rd", first_rd, 16'h0200);
        chk("p1_last_rd", last_rd, 16'h02FF);
        chk("p1_first_rd_at", 16'(first_rd_at), 16'd2);
        chk("p1_hold_addr", dif.bus_addr, 16'h02FF);
        chk("p1_hold_oaddr", 16'(dif.oam_addr), 16'h00FF);
        chk("p1_hold_odata", 16'(dif.oam_data), 16'(8'hFF ^ 8'h3A ^ 8'h5A));

        // Trigger landing with parity 0: ALIGN only when parity tracking is built in
        step();
        align_to(0); clr();
        cpu_access(REG_ADDR, 8'h02, 1'b0);
        wait_xfer(700);
        chk("p0_len", 16'(act_len), ALIGN_EN ? 16'd514 : 16'd513);
        chk("p0_first_rd_at", 16'(first_rd_at), ALIGN_EN ? 16'd3 : 16'd2);
        chk("p0_writes", 16'(wr_cnt), 16'd256);
        chk("p0_done_cnt", 16'(done_cnt), 16'd1);

        // Retrigger during an active transfer is ignored
        step();
        align_to(1); clr();
        cpu_access(REG_ADDR, 8'h02, 1'b0);
        repeat (99) step();
        cpu_access(REG_ADDR, 8'h07, 1'b0);
        wait_xfer(700);
        chk("rt_len", 16'(act_len), 16'd513);
        chk("rt_first_rd", first_rd, 16'h0200);
        chk("rt_last_rd", last_rd, 16'h02FF);
        chk("rt_writes", 16'(wr_cnt), 16'd256);

        // Neighbouring register write and a read of $4014 never start a transfer
        step(); clr();
        cpu_access(16'h4013, 8'h05, 1'b0);
        cpu_access(REG_ADDR, 8'h06, 1'b1);
        repeat (20) step();
        chk("noxfer_len", 16'(act_len), 16'd0);
        chk("noxfer_writes", 16'(wr_cnt), 16'd0);

        // Asynchronous abort after 40 OAM writes, then a fresh transfer from $0300
        clr();
        cpu_access(REG_ADDR, 8'h02, 1'b0);
        n = 0;
        while (wr_cnt < 40 && n < 200) begin
            step();
            n++;
        end
        chk("abort_reach40", 16'(wr_cnt), 16'd40);
        @(posedge CLK);
        #2 RESET_n = 1'b0;
        #1 chk_zero_outputs("abort");
        repeat (5) step();
        chk("abort_writes", 16'(wr_cnt), 16'd40);
        RESET_n = 1'b1;
        step(); clr();
        cpu_access(REG_ADDR, 8'h03, 1'b0);
        wait_xfer(700);
        chk("restart_first_rd", first_rd, 16'h0300);
        chk("restart_last_rd", last_rd, 16'h03FF);
        chk("restart_writes", 16'(wr_cnt), 16'd256);
        chk("restart_done_cnt", 16'(done_cnt), 16'd1);
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/oam_dma_controller.md
Name: oam_dma_controller

Overview:
- Sequences the $4014 sprite DMA on the CPU bus: latches the page byte, stalls the CPU, and performs 256 read/write pairs from CPU address space into PPU OAM.
- Sits between the CPU, the CPU bus address mux and the PPU OAM write port; owns CPU-bus arbitration while a transfer is in flight.
- Replaces ad-hoc DMA sequencing with a cycle-accurate halt/align/get/put schedule (513 or 514 CPU cycles).

Parameters:
- REG_ADDR, 16'h4014, CPU write address that triggers a transfer
- XFER_LEN, 256, bytes per transfer; must be a power of two, max 256

Ports:
- CLK  in  1  CPU clock; all state changes on rising edge
- RESET_n  in  1  asynchronous, active-low reset
- cpu_addr  in  16  CPU-driven address
- cpu_data  in  8  CPU write data
- cpu_rw_n  in  1  CPU direction: 1 = read, 0 = write
- dma_active  out  1  high while a transfer runs; gates CPU enable low
- bus_own  out  1  DMA drives the CPU address bus this cycle
- bus_addr  out  16  DMA source address {page, idx}
- bus_rden  out  1  read strobe to system RAM/PRG/IO decode
- bus_data  in  8  read data returned by the bus; valid the cycle after bus_rden
- oam_wren  out  1  one-cycle OAM write strobe
- oam_addr  out  8  OAM byte index
- oam_data  out  8  OAM write data
- done  out  1  one-cycle pulse on the final OAM write

Behaviour:
- Reset (asynchronous, RESET_n low): state IDLE; page, idx, parity = 0; every output = 0. Reset mid-transfer aborts immediately with no further OAM writes.
- Parity flop: toggles every CLK after reset. 0 = get cycle, 1 = put cycle.
- States: IDLE, HALT, ALIGN, READ, WRITE.
- IDLE: if cpu_rw_n == 0 and cpu_addr == REG_ADDR, then page <= cpu_data, idx <= 0, next state HALT. Otherwise stay in IDLE.
- HALT: one dummy cycle; dma_active = 1 and bus_own = 0.
  - If current parity == 1, go to READ.
  - Else go to ALIGN.
- ALIGN: one dummy cycle, then READ. Invariant: READ always occurs with parity == 0.
- READ: bus_own = 1, bus_rden = 1, bus_addr = {page, idx}. Next state WRITE.
- WRITE: bus_own = 1, bus_rden = 0, bus_addr held.
  - oam_wren = 1, oam_addr = idx, oam_data = bus_data.
  - If idx == XFER_LEN-1: done = 1 and next state IDLE.
  - Else idx <= idx + 1 (8-bit wrap) and next state READ.
- dma_active = 1 in every non-IDLE state. It is registered, so it rises the cycle after the trigger write and falls the cycle after the final WRITE.
- Total dma_active length: 1 + 2*XFER_LEN, plus 1 when ALIGN is taken (513 or 514 cycles).
- Triggers while not in IDLE are ignored; page is not reloaded.
- A CPU read of REG_ADDR never triggers.
- oam_addr is always 0-based. Any OAMADDR offset is applied inside the PPU.
- Outputs bus_addr, oam_addr and oam_data hold their last value when idle; their strobes are 0.

Optional Feature:
- Macro: OAM_DMA_ODD_ALIGN_EN
- Defined: parity tracking and the ALIGN state as above (513/514-cycle transfers).
- Undefined: parity flop and ALIGN are removed; HALT always goes to READ. Every transfer is exactly 1 + 2*XFER_LEN = 513 cycles.

Test Plan:
- Trigger with parity = 1 in HALT: write 8'h02 to $4014 -> 256 reads from $0200..$02FF; oam_wren pulses with oam_addr 0..255 carrying RAM bytes; dma_active high exactly 513 cycles; done pulses once on the last write.
- Trigger with parity = 0 in HALT (macro defined): same data -> one ALIGN cycle inserted; dma_active high 514 cycles; every bus_rden coincides with parity 0.
- Same as previous, macro undefined -> dma_active high 513 cycles; no dummy cycle between HALT and first READ.
- Second write of 8'h07 to $4014 on cycle 100 of an active transfer -> ignored; page stays 8'h02 and the transfer completes normally.
- Write to $4013, then a CPU read of $4014 -> no transfer; dma_active stays 0.
- RESET_n pulled low after 40 OAM writes -> all outputs 0 asynchronously. After release, a new write of 8'h03 restarts from idx 0 at $0300.
